// File: rtl/read_nonsym_pattern_source.sv
// Pipe-out read-throughput source: a deterministic 64-bit pattern generator feeds a
// block-RAM FIFO that is drained 32 bits per okPipeOut read, low half first.
module read_nonsym_pattern_source #(
    parameter int          DEPTH          = 512,
    parameter int          ADDR_W         = 9,
    parameter logic [31:0] UNDERFLOW_WORD = 32'h0000_0000
) (
    input  logic        okClk,
    input  logic        reset,
    input  logic        reset_pattern,
    input  logic        gen_enable,
    input  logic [1:0]  pattern_mode,
    input  logic [31:0] pattern_seed,
    input  logic [31:0] word_limit,
    input  logic        pipe_out_read,
    output logic [31:0] pipe_out_data,
    output logic        fifo_empty,
    output logic        fifo_full,
    output logic [31:0] words_read,
    output logic [31:0] underflow_count,
    output logic        done
);

    typedef enum logic [1:0] {
        MODE_COUNTER = 2'd0,
        MODE_WALK    = 2'd1,
        MODE_LFSR    = 2'd2,
        MODE_CONST   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        SRC_UNDERFLOW = 2'd0,
        SRC_LOW       = 2'd1,
        SRC_HIGH      = 2'd2
    } src_t;

    // Left-shifting Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS = 32'h0040_0007;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {v[30:0], 1'b0} ^ (v[31] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

    logic [63:0]     mem [DEPTH];
    logic [63:0]     rd_entry_reg;
    logic [ADDR_W:0] wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
    logic            fifo_empty_reg, fifo_full_reg, empty_next, full_next;
    logic            half_reg, half_next;
    src_t            src_reg;
    mode_t           mode_reg;
    logic [31:0]     gen_state_reg, gen_count_reg, gen_count_next;
    logic [31:0]     words_read_reg, underflow_count_reg;
    logic            done_reg, done_next;
    logic [31:0]     seed_state, odd_state, next_state, even_word, odd_word;
    logic            wr_en, pop, under_limit;

    // gen_state_reg holds seed+k for counter/walking-one, the word itself for LFSR/constant
    assign seed_state = (mode_t'(pattern_mode) == MODE_LFSR && pattern_seed == 32'd0)
                        ? 32'd1 : pattern_seed;

    always_comb begin
        odd_state  = gen_state_reg;
        next_state = gen_state_reg;
        case (mode_reg)
            MODE_COUNTER, MODE_WALK: begin
                odd_state  = gen_state_reg + 32'd1;
                next_state = gen_state_reg + 32'd2;
            end
            MODE_LFSR: begin
                odd_state  = lfsr_step(gen_state_reg);
                next_state = lfsr_step(odd_state);
            end
            default: begin
                odd_state  = gen_state_reg;
                next_state = gen_state_reg;
            end
        endcase
        even_word = (mode_reg == MODE_WALK) ? (32'd1 << gen_state_reg[4:0]) : gen_state_reg;
        odd_word  = (mode_reg == MODE_WALK) ? (32'd1 << odd_state[4:0]) : odd_state;
    end

    assign under_limit = (word_limit == 32'd0) || (gen_count_reg < word_limit);
    assign wr_en = ~reset & gen_enable & ~fifo_full_reg & ~reset_pattern & under_limit;
    assign pop   = ~reset & pipe_out_read & ~half_reg & ~fifo_empty_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg + {{ADDR_W{1'b0}}, wr_en};
        rd_ptr_next = rd_ptr_reg + {{ADDR_W{1'b0}}, pop};
        empty_next  = (wr_ptr_next == rd_ptr_next);
        full_next   = (wr_ptr_next[ADDR_W] != rd_ptr_next[ADDR_W]) &&
                      (wr_ptr_next[ADDR_W-1:0] == rd_ptr_next[ADDR_W-1:0]);
        half_next   = pipe_out_read ? (~half_reg & ~fifo_empty_reg) : half_reg;
        if (reset_pattern)
            gen_count_next = 32'd0;
        else if (wr_en && gen_count_reg != 32'hFFFF_FFFF)
            gen_count_next = gen_count_reg + 32'd1;
        else
            gen_count_next = gen_count_reg;
        done_next = (word_limit != 32'd0) && (gen_count_next == word_limit) &&
                    empty_next && ~half_next;
    end

    // Storage kept free of reset so it maps onto block RAM with a registered read port
    always_ff @(posedge okClk) begin
        if (wr_en)
            mem[wr_ptr_reg[ADDR_W-1:0]] <= {odd_word, even_word};
        if (pop)
            rd_entry_reg <= mem[rd_ptr_reg[ADDR_W-1:0]];
    end

    always_ff @(posedge okClk) begin
        if (reset) begin
            mode_reg            <= mode_t'(pattern_mode);
            gen_state_reg       <= seed_state;
            gen_count_reg       <= 32'd0;
            wr_ptr_reg          <= '0;
            rd_ptr_reg          <= '0;
            fifo_empty_reg      <= 1'b1;
            fifo_full_reg       <= 1'b0;
            half_reg            <= 1'b0;
            src_reg             <= SRC_UNDERFLOW;
            words_read_reg      <= 32'd0;
            underflow_count_reg <= 32'd0;
            done_reg            <= 1'b0;
        end else begin
            if (reset_pattern) begin
                mode_reg      <= mode_t'(pattern_mode);
                gen_state_reg <= seed_state;
            end else if (wr_en) begin
                gen_state_reg <= next_state;
            end
            gen_count_reg  <= gen_count_next;
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            fifo_empty_reg <= empty_next;
            fifo_full_reg  <= full_next;
            half_reg       <= half_next;
            done_reg       <= done_next;
            if (pipe_out_read) begin
                if (half_reg) begin
                    src_reg <= SRC_HIGH;
                    if (words_read_reg != 32'hFFFF_FFFF)
                        words_read_reg <= words_read_reg + 32'd1;
                end else if (!fifo_empty_reg) begin
                    src_reg <= SRC_LOW;
                    if (words_read_reg != 32'hFFFF_FFFF)
                        words_read_reg <= words_read_reg + 32'd1;
                end else begin
                    src_reg <= SRC_UNDERFLOW;
                    if (underflow_count_reg != 32'hFFFF_FFFF)
                        underflow_count_reg <= underflow_count_reg + 32'd1;
                end
            end
        end
    end

    // The popped entry stays in rd_entry_reg, so it doubles as the pending-upper-half hold
    always_comb begin
        case (src_reg)
            SRC_LOW:  pipe_out_data = rd_entry_reg[31:0];
            SRC_HIGH: pipe_out_data = rd_entry_reg[63:32];
            default:  pipe_out_data = UNDERFLOW_WORD;
        endcase
    end

    assign fifo_empty      = fifo_empty_reg;
    assign fifo_full       = fifo_full_reg;
    assign words_read      = words_read_reg;
    assign underflow_count = underflow_count_reg;
    assign done            = done_reg;

endmodule

// File: tb/tb_read_nonsym_pattern_source.sv
// Bench for read_nonsym_pattern_source: word-stream queue model checked every cycle,
// directed scenarios with literal expectations, then randomized segments.
module tb_read_nonsym_pattern_source;

    localparam int          DEPTH  = 512;
    localparam int          ADDR_W = 9;
    localparam logic [31:0] UW     = 32'h0000_0000;
    localparam int          NREADS = 2 * DEPTH + 10;

    logic        okClk = 1'b0;
    logic        reset, reset_pattern, gen_enable, pipe_out_read;
    logic [1:0]  pattern_mode;
    logic [31:0] pattern_seed, word_limit;
    logic [31:0] pipe_out_data, words_read, underflow_count;
    logic        fifo_empty, fifo_full, done;

    always #5 okClk = ~okClk;

    read_nonsym_pattern_source #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .UNDERFLOW_WORD(UW)) dut (
        .okClk(okClk), .reset(reset), .reset_pattern(reset_pattern), .gen_enable(gen_enable),
        .pattern_mode(pattern_mode), .pattern_seed(pattern_seed), .word_limit(word_limit),
        .pipe_out_read(pipe_out_read), .pipe_out_data(pipe_out_data), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .words_read(words_read), .underflow_count(underflow_count),
        .done(done)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Multiply by x modulo the 33-bit polynomial x^32+x^22+x^2+x+1
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        logic [32:0] w;
        w = {v, 1'b0};
        if (w[32]) w = w ^ 33'h1_0040_0007;
        return w[31:0];
    endfunction

    function automatic logic [31:0] pat_word(input logic [1:0] mode, input logic [31:0] seed,
                                             input logic [31:0] k, input logic [31:0] lfsr);
        logic [31:0] s;
        s = seed + k;
        case (mode)
            2'd0:    return s;
            2'd1:    return 32'd1 << (s % 32);
            2'd2:    return lfsr;
            default: return seed;
        endcase
    endfunction

    // Model: the host-visible word stream as a queue; a FIFO entry is two queued words
    logic [31:0] q[$];
    logic [1:0]  m_mode;
    logic [31:0] m_seed, m_k, m_lfsr, m_gen, m_words, m_under, m_data;
    logic        m_done;
    logic        m_valid = 1'b0;

    initial begin
        logic full_pre;
        forever begin
            @(posedge okClk);
            if (reset) begin
                q.delete();
                m_mode = pattern_mode; m_seed = pattern_seed; m_k = 0;
                m_lfsr = (pattern_seed == 0) ? 32'd1 : pattern_seed;
                m_gen = 0; m_words = 0; m_under = 0; m_data = UW; m_done = 1'b0;
                m_valid = 1'b1;
            end else begin
                full_pre = (q.size() / 2 == DEPTH);
                if (pipe_out_read) begin
                    if (q.size() > 0) begin
                        m_data = q.pop_front();
                        if (m_words != 32'hFFFF_FFFF) m_words++;
                    end else begin
                        m_data = UW;
                        if (m_under != 32'hFFFF_FFFF) m_under++;
                    end
                end
                if (reset_pattern) begin
                    m_mode = pattern_mode; m_seed = pattern_seed; m_k = 0;
                    m_lfsr = (pattern_seed == 0) ? 32'd1 : pattern_seed;
                    m_gen = 0;
                end else if (gen_enable && !full_pre && (word_limit == 0 || m_gen < word_limit)) begin
                    for (int h = 0; h < 2; h++) begin
                        q.push_back(pat_word(m_mode, m_seed, m_k, m_lfsr));
                        m_k = m_k + 1;
                        m_lfsr = lfsr_step(m_lfsr);
                    end
                    if (m_gen != 32'hFFFF_FFFF) m_gen++;
                end
                m_done = (word_limit != 0) && (m_gen == word_limit) && (q.size() == 0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge okClk);
            if (m_valid) begin
                chk("data", pipe_out_data, m_data);
                chk("empty", {31'd0, fifo_empty}, {31'd0, (q.size() / 2 == 0)});
                chk("full", {31'd0, fifo_full}, {31'd0, (q.size() / 2 == DEPTH)});
                chk("words_read", words_read, m_words);
                chk("underflow", underflow_count, m_under);
                chk("done", {31'd0, done}, {31'd0, m_done});
            end
        end
    end

    task automatic tick();
        @(posedge okClk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_read(output logic [31:0] d);
        pipe_out_read = 1'b1;
        tick();
        pipe_out_read = 1'b0;
        d = pipe_out_data;
        $display("read data=%h words_read=%0d underflow=%0d", d, words_read, underflow_count);
    endtask

    initial begin
        logic [31:0] d;
        int n_const;
        bit found;
        logic [31:0] walk_exp [4];
        int rd_pct;

        reset = 1'b1; reset_pattern = 1'b0; gen_enable = 1'b0; pipe_out_read = 1'b0;
        pattern_mode = 2'd0; pattern_seed = 32'd0; word_limit = 32'd0;

        // Counter, limit 4: eight words then an underflow
        pattern_mode = 2'd0; pattern_seed = 32'h100; word_limit = 32'd4; gen_enable = 1'b1;
        apply_reset();
        chk("reset_data", pipe_out_data, 32'h0);
        chk("reset_empty", {31'd0, fifo_empty}, 32'd1);
        repeat (6) tick();
        for (int i = 0; i < 8; i++) begin
            do_read(d);
            chk("counter_word", d, 32'h100 + i);
        end
        chk("counter_done", {31'd0, done}, 32'd1);
        chk("counter_words", words_read, 32'd8);
        chk("counter_under0", underflow_count, 32'd0);
        do_read(d);
        chk("under_data", d, 32'h0);
        chk("under_count", underflow_count, 32'd1);
        chk("under_words", words_read, 32'd8);

        // Walking-one starting at bit 30
        walk_exp[0] = 32'h4000_0000; walk_exp[1] = 32'h8000_0000;
        walk_exp[2] = 32'h0000_0001; walk_exp[3] = 32'h0000_0002;
        pattern_mode = 2'd1; pattern_seed = 32'd30; word_limit = 32'd0;
        apply_reset();
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            do_read(d);
            chk("walk_word", d, walk_exp[i]);
        end

        // LFSR seed 0: fill to full, then continuous reads
        pattern_mode = 2'd2; pattern_seed = 32'd0; word_limit = 32'd0;
        apply_reset();
        for (int i = 0; i < DEPTH + 50 && !fifo_full; i++) tick();
        chk("lfsr_filled", {31'd0, fifo_full}, 32'd1);
        pipe_out_read = 1'b1;
        for (int i = 0; i < NREADS; i++) begin
            tick();
            if (i == 0) begin
                chk("lfsr_w0", pipe_out_data, 32'h0000_0001);
                chk("lfsr_full_drop", {31'd0, fifo_full}, 32'd0);
            end
            if (i == 1)  chk("lfsr_w1", pipe_out_data, 32'h0000_0002);
            if (i == 31) chk("lfsr_w31", pipe_out_data, 32'h8000_0000);
            if (i == 32) chk("lfsr_w32", pipe_out_data, 32'h0040_0007);
        end
        pipe_out_read = 1'b0;
        $display("lfsr stream words_read=%0d underflow=%0d", words_read, underflow_count);
        chk("lfsr_no_gaps", underflow_count, 32'd0);
        chk("lfsr_words", words_read, NREADS);

        // Reset mid-transfer with an upper half pending
        pattern_mode = 2'd0; pattern_seed = 32'd0; word_limit = 32'd0;
        apply_reset();
        repeat (4) tick();
        for (int i = 0; i < 3; i++) do_read(d);
        gen_enable = 1'b0;
        apply_reset();
        chk("mid_reset_data", pipe_out_data, 32'h0);
        chk("mid_reset_empty", {31'd0, fifo_empty}, 32'd1);
        chk("mid_reset_full", {31'd0, fifo_full}, 32'd0);
        chk("mid_reset_words", words_read, 32'd0);
        chk("mid_reset_under", underflow_count, 32'd0);
        chk("mid_reset_done", {31'd0, done}, 32'd0);
        do_read(d);
        chk("mid_reset_read", d, 32'h0);
        chk("mid_reset_under1", underflow_count, 32'd1);

        // Constant stream, two reset_pattern pulses, second switching to counter
        pattern_mode = 2'd3; pattern_seed = 32'hA5A5_A5A5; word_limit = 32'd0; gen_enable = 1'b1;
        apply_reset();
        repeat (3) tick();
        reset_pattern = 1'b1; tick(); reset_pattern = 1'b0;
        tick();
        pattern_mode = 2'd0; pattern_seed = 32'h1000;
        reset_pattern = 1'b1; tick(); reset_pattern = 1'b0;
        repeat (2) tick();
        n_const = 0; found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            do_read(d);
            if (d == 32'hA5A5_A5A5) n_const++;
            else found = 1'b1;
        end
        chk("rp_old_words", n_const, 32'd8);
        chk("rp_new_first", d, 32'h1000);
        do_read(d);
        chk("rp_new_second", d, 32'h1001);

        // Randomized segments; mode/seed wiggle freely between pulses
        for (int s = 0; s < 8; s++) begin
            rd_pct = (s % 2 == 0) ? 10 : 70;
            pattern_mode = 2'($urandom_range(0, 3));
            pattern_seed = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            word_limit = (s % 2 == 0 || $urandom_range(0, 2) == 0) ? 32'd0 : $urandom_range(1, 40);
            apply_reset();
            repeat (1200) begin
                gen_enable    = ($urandom_range(0, 9) < 8);
                pipe_out_read = ($urandom_range(0, 99) < rd_pct);
                reset_pattern = ($urandom_range(0, 199) == 0);
                reset         = ($urandom_range(0, 999) == 0);
                pattern_mode  = 2'($urandom_range(0, 3));
                pattern_seed  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
                tick();
            end
            reset = 1'b0; reset_pattern = 1'b0; pipe_out_read = 1'b0;
            $display("segment %0d words_read=%0d underflow=%0d", s, words_read, underflow_count);
        end

        @(negedge okClk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/read_nonsym_pattern_source.md
Name: read_nonsym_pattern_source

Overview:
- Source side of the pipe-out read-throughput test; the counterpart of the pipe-in write test and its 64-bit error checker.
- Generates a deterministic 64-bit pattern stream and buffers it in an internal 64-bit-wide FIFO.
- Serializes each FIFO entry into two 32-bit words for the okPipeOut endpoint (ep_read / ep_datain), low half first.
- Host-side word n equals pattern word n, so host software runs the same checker algorithm used for writes.

Parameters:
- DEPTH, 512, FIFO depth in 64-bit entries; power of two, minimum 4.
- ADDR_W, 9, log2(DEPTH).
- UNDERFLOW_WORD, 32'h0000_0000, value presented on a read from an empty source.

Ports:
- okClk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- reset_pattern  input  1  one-cycle pulse; restarts generator at seed and clears generated count; FIFO contents kept.
- gen_enable  input  1  level; generator may write the FIFO while high.
- pattern_mode  input  2  0 counter, 1 walking-one, 2 LFSR, 3 constant.
- pattern_seed  input  32  start value.
- word_limit  input  32  number of 64-bit entries to generate; 0 means unlimited.
- pipe_out_read  input  1  okPipeOut ep_read.
- pipe_out_data  output  32  okPipeOut ep_datain, registered.
- fifo_empty  output  1  FIFO holds no entries.
- fifo_full  output  1  FIFO holds DEPTH entries.
- words_read  output  32  count of 32-bit words delivered, underflows excluded.
- underflow_count  output  32  count of reads with no data available.
- done  output  1  limit reached and all data drained.

Behaviour:
- Reset values: pipe_out_data=UNDERFLOW_WORD; fifo_empty=1; fifo_full=0; words_read=0; underflow_count=0; done=0. FIFO pointers, half-select, generator state and generated count are cleared.
- reset has priority over every other input; reset mid-transfer discards all buffered data.
- Pattern, defined per 32-bit word k (k from 0, as seen by the host):
  - counter: seed+k, mod 2^32.
  - walking-one: 1 rotated left by ((seed+k) mod 32).
  - LFSR: Galois x^32+x^22+x^2+x+1; word 0 = seed, or 1 if seed=0; word k+1 = step(word k).
  - constant: seed.
- Generator:
  - Produces entry {word 2j+1, word 2j} in one cycle: upper half = odd word, lower half = even word.
  - Writes when gen_enable & ~fifo_full & (word_limit==0 | gen_count<word_limit); advances two words per write.
  - pattern_mode and seed are sampled on reset_pattern or reset only; later changes have no effect until the next pulse.
  - reset_pattern coincident with a write: the write is suppressed that cycle.
- FIFO:
  - Circular, DEPTH entries, ADDR_W+1-bit pointers.
  - fifo_full and fifo_empty are registered and exact; a simultaneous write and pop keep the occupancy unchanged.
  - A write while full never occurs; the generator is gated.
- Read side:
  - hold register plus half flag. On pipe_out_read, pipe_out_data is updated at that same edge, so the new value is visible the cycle after the read strobe (standard-FIFO timing).
  - Order: lower half of an entry first, then upper half. The entry is popped when its lower half is taken; the upper half is held for the next read.
  - Read with a pending upper half: present it and increment words_read.
  - Read with no pending half and FIFO non-empty: pop, present the lower half, increment words_read.
  - Read with no pending half and FIFO empty: present UNDERFLOW_WORD, increment underflow_count. Stream position does not advance.
  - Back-to-back reads every cycle are sustained at 1 word/cycle, provided the generator keeps up (it does, at 2 words/cycle).
- Counters saturate at 2^32-1.
- done = (word_limit!=0) & (gen_count==word_limit) & fifo_empty & no pending half; registered.

Test Plan:
- Counter, seed=0x100, limit=4, gen_enable=1, 8 reads -> data 0x100..0x107 in order; done=1 after the 8th read; words_read=8; underflow_count=0.
- Same setup, then a 9th read -> pipe_out_data=0x0; underflow_count=1; words_read stays 8.
- LFSR, seed=0, limit=0, fill until fifo_full (DEPTH entries), then 2*DEPTH+10 continuous reads -> word0=1, each next word = Galois step; no gaps; fifo_full deasserts after the first pop.
- Walking-one, seed=30, 4 reads -> 0x40000000, 0x80000000, 0x00000001, 0x00000002.
- Counter stream; after 3 reads (one upper half pending), assert reset -> all outputs at reset values; fifo_empty=1; a read then yields an underflow.
- Constant seed=0xA5A5A5A5, reset_pattern pulsed coincident with a write, change mode to counter and pulse again -> no torn entry; new stream restarts at seed; entries already buffered are still delivered first.
